// File: rtl/pipe_pkg.sv
// Shared widths and control-field bit positions for pipeline stage registers.
package pipe_pkg;

  localparam int CTRL_W_DEF = 16;
  localparam int DATA_W_DEF = 128;
  localparam int PERF_W_DEF = 16;

  // Control-field bit positions; a zero field is an inactive bubble.
  localparam int CTRL_REG_WE_BIT  = 0;
  localparam int CTRL_MEM_RD_BIT  = 1;
  localparam int CTRL_MEM_WR_BIT  = 2;
  localparam int CTRL_BRANCH_BIT  = 3;
  localparam int CTRL_JUMP_BIT    = 4;
  localparam int CTRL_ALU_OP_LSB  = 8;
  localparam int CTRL_ALU_OP_MSB  = 11;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready handshake bundle around one stage: upstream (in_*) and downstream (out_*) sides.
interface pipe_stage_reg_if #(
  parameter int CTRL_W = 16,
  parameter int DATA_W = 128
);
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_ctrl, in_data, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data
  );

  modport slave (
    input  in_valid, in_ctrl, in_data, out_ready,
    output in_ready, out_valid, out_ctrl, out_data
  );
endinterface

// File: rtl/pipe_perf_cnt.sv
// Saturating event counter with synchronous clear; updates on the falling clock edge.
module pipe_perf_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_reg;

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (en && (cnt_reg != {W{1'b1}})) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign cnt = cnt_reg;

endmodule

// File: rtl/pipe_stage_reg.sv
// Two-entry (main + skid) pipeline register with flush and bubble ctrl zeroing.
// Optional performance counters are built when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int PERF_W = PERF_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  pipe_stage_reg_if.slave   bus,
  output logic [PERF_W-1:0] perf_stall_cnt,
  output logic [PERF_W-1:0] perf_bubble_cnt
);

  logic              main_valid_reg;
  logic [CTRL_W-1:0] main_ctrl_reg;
  logic [DATA_W-1:0] main_data_reg;
  logic              skid_valid_reg;
  logic [CTRL_W-1:0] skid_ctrl_reg;
  logic [DATA_W-1:0] skid_data_reg;

  logic accept;
  logic retire;

  // in_ready comes straight from the skid flop, so out_ready never reaches it.
  assign accept = bus.in_valid & ~skid_valid_reg;
  assign retire = main_valid_reg & bus.out_ready;

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_reg <= 1'b0;
      main_ctrl_reg  <= '0;
      main_data_reg  <= '0;
      skid_valid_reg <= 1'b0;
      skid_ctrl_reg  <= '0;
      skid_data_reg  <= '0;
    end else if (flush) begin
      main_valid_reg <= 1'b0;
      skid_valid_reg <= 1'b0;
    end else if (skid_valid_reg) begin
      if (retire) begin
        main_ctrl_reg  <= skid_ctrl_reg;
        main_data_reg  <= skid_data_reg;
        skid_valid_reg <= 1'b0;
      end
    end else if (accept) begin
      if (!main_valid_reg || retire) begin
        main_valid_reg <= 1'b1;
        main_ctrl_reg  <= bus.in_ctrl;
        main_data_reg  <= bus.in_data;
      end else begin
        skid_valid_reg <= 1'b1;
        skid_ctrl_reg  <= bus.in_ctrl;
        skid_data_reg  <= bus.in_data;
      end
    end else if (retire) begin
      main_valid_reg <= 1'b0;
    end
  end

  assign bus.in_ready  = ~skid_valid_reg;
  assign bus.out_valid = main_valid_reg;
  assign bus.out_ctrl  = main_valid_reg ? main_ctrl_reg : '0;
  assign bus.out_data  = main_data_reg;

`ifdef PIPE_STAGE_PERF_EN
  pipe_perf_cnt #(.W(PERF_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .en    (main_valid_reg & ~bus.out_ready),
    .cnt   (perf_stall_cnt)
  );

  pipe_perf_cnt #(.W(PERF_W)) u_bubble_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .en    (~main_valid_reg),
    .cnt   (perf_bubble_cnt)
  );
`else
  assign perf_stall_cnt  = '0;
  assign perf_bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and randomized checks of pipe_stage_reg against hand values and a queue model.
module tb_pipe_stage_reg;
  localparam int CW = 16;
  localparam int DW = 128;
  localparam int PW = 4;
`ifdef PIPE_STAGE_PERF_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic [PW-1:0] perf_stall_cnt;
  logic [PW-1:0] perf_bubble_cnt;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;
  ent_t q[$];

  pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) bus ();

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .PERF_W(PW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .flush           (flush),
    .bus             (bus),
    .perf_stall_cnt  (perf_stall_cnt),
    .perf_bubble_cnt (perf_bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // State changes on the falling edge; sample 1 time unit later.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d, input logic rdy);
    bus.in_valid  = v;
    bus.in_ctrl   = c;
    bus.in_data   = d;
    bus.out_ready = rdy;
  endtask

  initial begin
    drive(1'b0, '0, '0, 1'b0);

    // Reset state, before any edge
    #1;
    check_val("rst_out_valid", DW'(bus.out_valid), DW'(0));
    check_val("rst_out_ctrl", DW'(bus.out_ctrl), DW'(0));
    check_val("rst_out_data", bus.out_data, DW'(0));
    check_val("rst_in_ready", DW'(bus.in_ready), DW'(1));
    check_val("rst_stall", DW'(perf_stall_cnt), DW'(0));
    check_val("rst_bubble", DW'(perf_bubble_cnt), DW'(0));
    $display("reset state checked");

    // Single accept, one-edge latency, bubble afterwards
    tick();
    rst_n = 1'b1;
    drive(1'b1, 16'h00A5, 128'h1234, 1'b1);
    tick();
    check_val("single_valid", DW'(bus.out_valid), DW'(1));
    check_val("single_ctrl", DW'(bus.out_ctrl), DW'(16'h00A5));
    check_val("single_data", bus.out_data, DW'(128'h1234));
    drive(1'b0, '0, '0, 1'b1);
    tick();
    check_val("single_gone_valid", DW'(bus.out_valid), DW'(0));
    check_val("single_gone_ctrl", DW'(bus.out_ctrl), DW'(0));
    check_val("single_hold_data", bus.out_data, DW'(128'h1234));
    $display("single accept checked");

    // Stream A,B,C into a stalled stage, then drain
    drive(1'b1, 16'h000A, 128'hAAAA, 1'b0);
    tick();
    check_val("strm_a_data", bus.out_data, DW'(128'hAAAA));
    check_val("strm_a_ready", DW'(bus.in_ready), DW'(1));
    drive(1'b1, 16'h000B, 128'hBBBB, 1'b0);
    tick();
    check_val("strm_b_ready", DW'(bus.in_ready), DW'(0));
    check_val("strm_b_head", bus.out_data, DW'(128'hAAAA));
    drive(1'b1, 16'h000C, 128'hCCCC, 1'b0);
    tick();
    check_val("strm_c_held_ready", DW'(bus.in_ready), DW'(0));
    check_val("strm_c_held_head", DW'(bus.out_ctrl), DW'(16'h000A));
    bus.out_ready = 1'b1;
    tick();
    check_val("drain1_data", bus.out_data, DW'(128'hBBBB));
    check_val("drain1_ready", DW'(bus.in_ready), DW'(1));
    tick();
    check_val("drain2_data", bus.out_data, DW'(128'hCCCC));
    check_val("drain2_ctrl", DW'(bus.out_ctrl), DW'(16'h000C));
    bus.in_valid = 1'b0;
    tick();
    check_val("drain3_valid", DW'(bus.out_valid), DW'(0));
    $display("stream A,B,C checked");

    // Flush with both entries full and an incoming entry
    drive(1'b1, 16'h000D, 128'hDDDD, 1'b0);
    tick();
    drive(1'b1, 16'h000E, 128'hEEEE, 1'b0);
    tick();
    check_val("pre_flush_ready", DW'(bus.in_ready), DW'(0));
    drive(1'b1, 16'h000F, 128'hFFFF, 1'b0);
    flush = 1'b1;
    tick();
    check_val("flush_valid", DW'(bus.out_valid), DW'(0));
    check_val("flush_ready", DW'(bus.in_ready), DW'(1));
    check_val("flush_ctrl", DW'(bus.out_ctrl), DW'(0));
    flush = 1'b0;
    drive(1'b0, '0, '0, 1'b1);
    tick();
    check_val("flush_no_f", DW'(bus.out_valid), DW'(0));
    $display("flush checked");

    // Asynchronous reset between edges
    drive(1'b1, 16'h0077, 128'h7777, 1'b0);
    tick();
    check_val("pre_arst_valid", DW'(bus.out_valid), DW'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check_val("arst_valid", DW'(bus.out_valid), DW'(0));
    check_val("arst_ctrl", DW'(bus.out_ctrl), DW'(0));
    check_val("arst_data", bus.out_data, DW'(0));
    check_val("arst_ready", DW'(bus.in_ready), DW'(1));
    drive(1'b0, '0, '0, 1'b0);
    #1;
    rst_n = 1'b1;
    tick();
    check_val("post_arst_valid", DW'(bus.out_valid), DW'(0));
    $display("async reset checked");

    // Performance counters: saturating stall count, flush clear, bubble count
    drive(1'b1, 16'h0055, 128'h5555, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    repeat (20) tick();
    check_val("stall_valid", DW'(bus.out_valid), DW'(1));
    check_val("stall_sat", DW'(perf_stall_cnt), PERF_ON ? DW'(15) : DW'(0));
    flush = 1'b1;
    tick();
    check_val("stall_flush", DW'(perf_stall_cnt), DW'(0));
    check_val("bubble_flush", DW'(perf_bubble_cnt), DW'(0));
    flush = 1'b0;
    repeat (3) tick();
    check_val("bubble_three", DW'(perf_bubble_cnt), PERF_ON ? DW'(3) : DW'(0));
    $display("perf counters checked");

    // Randomized traffic against a reference queue (stage is empty here)
    for (int i = 0; i < 10000; i++) begin
      check_val("rnd_valid", DW'(bus.out_valid), DW'(q.size() != 0));
      check_val("rnd_ready", DW'(bus.in_ready), DW'(q.size() < 2));
      if (q.size() != 0) begin
        check_val("rnd_data", bus.out_data, q[0].d);
        check_val("rnd_ctrl", DW'(bus.out_ctrl), DW'(q[0].c));
      end else begin
        check_val("rnd_ctrl_bubble", DW'(bus.out_ctrl), DW'(0));
      end
      drive(1'($urandom_range(0, 1)), 16'($urandom),
            {$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)));
      flush = ($urandom_range(0, 31) == 0);
      if (flush) begin
        q.delete();
      end else begin
        logic acc;
        acc = bus.in_valid && (q.size() < 2);
        if ((q.size() != 0) && bus.out_ready) void'(q.pop_front());
        if (acc) q.push_back('{c: bus.in_ctrl, d: bus.in_data});
      end
      tick();
    end
    flush = 1'b0;
    $display("random traffic checked");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter CTRL_W, default 16: width of control field (zeroed on bubble).
REQ-002 Parameter DATA_W, default 128: width of payload field (operands, PC+4, immediates, register addresses).
REQ-003 Parameter PERF_W, default 16: width of performance counters.
REQ-004 clk  in  1  stage clock; all state updates on falling edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 flush  in  1  kill all held and incoming entries.
REQ-007 in_valid  in  1  upstream entry present.
REQ-008 in_ready  out  1  stage can accept an entry.
REQ-009 in_ctrl  in  CTRL_W  upstream control field.
REQ-010 in_data  in  DATA_W  upstream payload.
REQ-011 out_valid  out  1  downstream entry present.
REQ-012 out_ready  in  1  downstream accepts entry.
REQ-013 out_ctrl  out  CTRL_W  control field; all-zero whenever out_valid=0.
REQ-014 out_data  out  DATA_W  payload of head entry.
REQ-015 perf_stall_cnt  out  PERF_W  cycles with out_valid=1 and out_ready=0 (only with PIPE_STAGE_PERF_EN).
REQ-016 perf_bubble_cnt  out  PERF_W  cycles with out_valid=0 (only with PIPE_STAGE_PERF_EN).

Function
REQ-017 Storage SHALL be two entries: main (drives outputs) and skid (overflow), each with a valid bit.
REQ-018 in_ready SHALL equal NOT skid.valid, registered, with no combinational path from out_ready.
REQ-019 Accept SHALL occur on an edge where in_valid=1 and in_ready=1; retire SHALL occur where out_valid=1 and out_ready=1.
REQ-020 Latency SHALL be one edge: an entry accepted into an empty stage appears on outputs immediately after that edge.
REQ-021 Accept while main empty or retiring SHALL load main; accept while main held (not retiring) SHALL load skid.
REQ-022 Retire with skid valid SHALL move skid to main and clear skid; a simultaneous accept then SHALL be impossible (in_ready=0).
REQ-023 Retire with skid empty and no accept SHALL clear main.valid.
REQ-024 Entries SHALL leave in accept order; no entry is duplicated or dropped except by flush.
REQ-025 flush=1 SHALL, at the next edge, clear both valid bits and discard any same-edge input, regardless of in_valid/out_ready.
REQ-026 out_ctrl SHALL be forced to zero when main.valid=0, so a bubble drives every downstream control inactive.
REQ-027 out_data SHALL hold its last value when main.valid=0 (not required to be zero).
REQ-028 flush SHALL take priority over accept and retire on the same edge.

Reset
REQ-029 rst_n=0 SHALL immediately clear both valid bits, zero stored ctrl and data, drive out_valid=0, out_ctrl=0, out_data=0, in_ready=1, both counters 0.
REQ-030 Reset deassertion SHALL take effect on the next falling edge of clk; entries in flight during reset are lost.

Configuration
REQ-031 Macro PIPE_STAGE_PERF_EN defined: counters present, saturating at all-ones, cleared by reset or flush.
REQ-032 Macro undefined: counter outputs SHALL be tied to zero and no counter flops synthesised.

Structure
REQ-033 Shared package pipe_pkg SHALL hold the default widths and the per-stage control-field bit-position constants.
REQ-034 Sub-module pipe_perf_cnt (one saturating counter, enable plus clear) SHALL be instantiated twice.

Verification
REQ-035 Reset then single accept in_ctrl=0x00A5, in_data=0x1234 with out_ready=1 -> after one edge out_valid=1, out_ctrl=0x00A5; next edge out_valid=0, out_ctrl=0.
REQ-036 Stream A,B,C with out_ready=0 -> A in main, B in skid, in_ready=0, C held upstream; out_ready=1 for three edges -> A,B,C in order.
REQ-037 flush=1 with both entries full and in_valid=1 -> next edge out_valid=0, in_ready=1, out_ctrl=0, incoming entry absent downstream.
REQ-038 rst_n pulsed low mid-stream between edges -> outputs zero immediately, in_ready=1, no edge required.
REQ-039 PIPE_STAGE_PERF_EN, PERF_W=4, out_ready=0 with out_valid=1 for 20 edges -> perf_stall_cnt=15 (saturated); flush -> 0.
REQ-040 Random in_valid/out_ready/flush for 10000 edges against reference queue model -> zero order or data mismatches.
